// File: rtl/avalon_uart.sv
// 8N1 UART on an Avalon-MM slave: TX/RX FIFOs, programmable baud divisor, sticky errors.
// Optional interrupt output and IE register when AVALON_UART_IRQ_EN is defined.

module avalon_uart_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata_c,
  output logic             full_c,
  output logic             empty_c
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty; a pop frees a slot for a same-cycle push
  assign empty_c = (wr_ptr == rd_ptr);
  assign full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty_c;
  assign do_push = push && (!full_c || do_pop);
  assign rdata_c = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

module avalon_uart #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned DEFAULT_DIV = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        avn_read,
  input  logic        avn_write,
  input  logic [4:0]  avn_address,
  input  logic [3:0]  avn_byte_enable,
  input  logic [31:0] avn_writedata,
  output logic [31:0] avn_readdata,
  output logic        avn_waitrequest,
  output logic        uart_txd,
`ifdef AVALON_UART_IRQ_EN
  output logic        irq,
`endif
  input  logic        uart_rxd
);
  localparam int unsigned DIVW = 16;
  localparam logic [2:0] ADDR_TXDATA = 3'd0;
  localparam logic [2:0] ADDR_RXDATA = 3'd1;
  localparam logic [2:0] ADDR_CTRL   = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;
  localparam logic [2:0] ADDR_DIV    = 3'd4;
  localparam logic [2:0] ADDR_IE     = 3'd5;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic [2:0]      word;
  logic            wr_txdata, rd_rxdata, wr_ctrl, wr_status, wr_div;
  logic [1:0]      ctrl;
  logic [DIVW-1:0] div_q, div_new, div_wr;
  logic            rx_overrun, frame_err, rx_overrun_set, frame_err_set;
  logic [31:0]     rd_data, status;

  logic [7:0]      tx_rdata, rx_rdata;
  logic            tx_full, tx_empty, rx_full, rx_empty;
  logic            tx_pop, tx_busy, rx_push;

  tx_state_t       tx_state, tx_state_d;
  logic [DIVW-1:0] tx_cnt, tx_cnt_d, tx_div, tx_div_d;
  logic [2:0]      tx_bit, tx_bit_d;
  logic [7:0]      tx_shift, tx_shift_d;
  logic            tx_last, tx_go, txd_d;

  rx_state_t       rx_state, rx_state_d;
  logic [DIVW-1:0] rx_cnt, rx_cnt_d, rx_div, rx_div_d, rx_half;
  logic [2:0]      rx_bit, rx_bit_d;
  logic [7:0]      rx_shift, rx_shift_d;
  logic            rxd_meta, rxd_sync, rxd_prev, rx_fall;

  logic            unused_ok;

  assign unused_ok       = &{1'b0, avn_writedata[31:16], avn_byte_enable[3:2], avn_address[1:0]};
  assign avn_waitrequest = 1'b0;

  assign word      = avn_address[4:2];
  assign wr_txdata = avn_write && (word == ADDR_TXDATA) && avn_byte_enable[0];
  assign rd_rxdata = avn_read  && (word == ADDR_RXDATA);
  assign wr_ctrl   = avn_write && (word == ADDR_CTRL)   && avn_byte_enable[0];
  assign wr_status = avn_write && (word == ADDR_STATUS) && avn_byte_enable[0];
  assign wr_div    = avn_write && (word == ADDR_DIV);

  avalon_uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(wr_txdata), .wdata(avn_writedata[7:0]), .pop(tx_pop),
    .rdata_c(tx_rdata), .full_c(tx_full), .empty_c(tx_empty)
  );

  avalon_uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .wdata(rx_shift), .pop(rd_rxdata),
    .rdata_c(rx_rdata), .full_c(rx_full), .empty_c(rx_empty)
  );

  // Byte-lane merge of a DIV write, clamped so every bit lasts at least two clocks
  always_comb begin
    div_new = div_q;
    if (avn_byte_enable[0]) div_new[7:0]  = avn_writedata[7:0];
    if (avn_byte_enable[1]) div_new[15:8] = avn_writedata[15:8];
    div_wr = (div_new < DIVW'(2)) ? DIVW'(2) : div_new;
  end

  // A CPU pop in the same cycle makes room, so only a genuinely full FIFO overruns
  assign rx_overrun_set = rx_push && rx_full && !rd_rxdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl       <= '0;
      div_q      <= DIVW'(DEFAULT_DIV);
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl  <= avn_writedata[1:0];
      if (wr_div)  div_q <= div_wr;
      rx_overrun <= rx_overrun_set | (rx_overrun & ~(wr_status & avn_writedata[5]));
      frame_err  <= frame_err_set  | (frame_err  & ~(wr_status & avn_writedata[6]));
    end
  end

  assign tx_busy = (tx_state != TX_IDLE);
  assign status  = {25'b0, frame_err, rx_overrun, tx_busy, rx_empty, rx_full, tx_empty, tx_full};

`ifdef AVALON_UART_IRQ_EN
  logic [2:0] ie;
  always_ff @(posedge clk) begin
    if (rst) begin
      ie  <= '0;
      irq <= 1'b0;
    end else begin
      if (avn_write && (word == ADDR_IE) && avn_byte_enable[0]) ie <= avn_writedata[2:0];
      irq <= (ie[0] & tx_empty) | (ie[1] & ~rx_empty) | (ie[2] & (rx_overrun | frame_err));
    end
  end
`endif

  always_comb begin
    rd_data = '0;
    case (word)
      ADDR_TXDATA: rd_data = {tx_full, 31'b0};
      ADDR_RXDATA: rd_data = rx_empty ? {1'b1, 31'b0} : {1'b0, 23'b0, rx_rdata};
      ADDR_CTRL:   rd_data = {30'b0, ctrl};
      ADDR_STATUS: rd_data = status;
      ADDR_DIV:    rd_data = {16'b0, div_q};
`ifdef AVALON_UART_IRQ_EN
      ADDR_IE:     rd_data = {29'b0, ie};
`endif
      default:     rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)           avn_readdata <= '0;
    else if (avn_read) avn_readdata <= rd_data;
  end

  // TX: divisor is latched at each frame start; txd is registered alongside the state
  assign tx_last = (tx_cnt == (tx_div - DIVW'(1)));
  assign tx_go   = ctrl[0] && !tx_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_div   <= DIVW'(DEFAULT_DIV);
      tx_bit   <= '0;
      tx_shift <= '0;
      uart_txd <= 1'b1;
    end else begin
      tx_state <= tx_state_d;
      tx_cnt   <= tx_cnt_d;
      tx_div   <= tx_div_d;
      tx_bit   <= tx_bit_d;
      tx_shift <= tx_shift_d;
      uart_txd <= txd_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d   = tx_cnt + DIVW'(1);
    tx_div_d   = tx_div;
    tx_bit_d   = tx_bit;
    tx_shift_d = tx_shift;
    txd_d      = uart_txd;
    tx_pop     = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_cnt_d = '0;
        txd_d    = 1'b1;
        if (tx_go) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_rdata;
          tx_div_d   = div_q;
          tx_state_d = TX_START;
          txd_d      = 1'b0;
        end
      end
      TX_START: begin
        if (tx_last) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
          txd_d      = tx_shift[0];
        end
      end
      TX_DATA: begin
        if (tx_last) begin
          tx_cnt_d = '0;
          if (tx_bit == 3'd7) begin
            tx_state_d = TX_STOP;
            txd_d      = 1'b1;
          end else begin
            tx_bit_d   = tx_bit + 3'd1;
            tx_shift_d = {1'b0, tx_shift[7:1]};
            txd_d      = tx_shift[1];
          end
        end
      end
      TX_STOP: begin
        if (tx_last) begin
          tx_cnt_d = '0;
          if (tx_go) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_rdata;
            tx_div_d   = div_q;
            tx_state_d = TX_START;
            txd_d      = 1'b0;
          end else begin
            tx_state_d = TX_IDLE;
            txd_d      = 1'b1;
          end
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        txd_d      = 1'b1;
      end
    endcase
  end

  // RX: two-flop synchronizer plus one history flop for start-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  assign rx_fall = rxd_prev & ~rxd_sync;
  assign rx_half = {1'b0, rx_div[DIVW-1:1]} - DIVW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_div   <= DIVW'(DEFAULT_DIV);
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_d;
      rx_cnt   <= rx_cnt_d;
      rx_div   <= rx_div_d;
      rx_bit   <= rx_bit_d;
      rx_shift <= rx_shift_d;
    end
  end

  always_comb begin
    rx_state_d    = rx_state;
    rx_cnt_d      = rx_cnt + DIVW'(1);
    rx_div_d      = rx_div;
    rx_bit_d      = rx_bit;
    rx_shift_d    = rx_shift;
    rx_push       = 1'b0;
    frame_err_set = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (ctrl[1] && rx_fall) begin
          rx_div_d   = div_q;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt == rx_half) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rxd_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == (rx_div - DIVW'(1))) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rxd_sync, rx_shift[7:1]};
          if (rx_bit == 3'd7) rx_state_d = RX_STOP;
          else                rx_bit_d   = rx_bit + 3'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt == (rx_div - DIVW'(1))) begin
          rx_cnt_d      = '0;
          rx_push       = rxd_sync;
          frame_err_set = ~rxd_sync;
          rx_state_d    = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
    if (!ctrl[1]) begin
      rx_state_d    = RX_IDLE;
      rx_push       = 1'b0;
      frame_err_set = 1'b0;
    end
  end
endmodule

// File: tb/tb_avalon_uart.sv
// Directed bench for avalon_uart: register access, TX waveform, loopback RX and RX error paths.
module tb_avalon_uart;
  localparam logic [4:0] A_TXDATA = 5'h00;
  localparam logic [4:0] A_RXDATA = 5'h04;
  localparam logic [4:0] A_CTRL   = 5'h08;
  localparam logic [4:0] A_STATUS = 5'h0C;
  localparam logic [4:0] A_DIV    = 5'h10;
  localparam logic [4:0] A_IE     = 5'h14;
  localparam logic [4:0] A_UNMAP  = 5'h18;

  logic        clk = 1'b0;
  logic        rst;
  logic        avn_read, avn_write;
  logic [4:0]  avn_address;
  logic [3:0]  avn_byte_enable;
  logic [31:0] avn_writedata, avn_readdata;
  logic        avn_waitrequest, uart_txd, uart_rxd;
  logic        lb, rxd_drv;
`ifdef AVALON_UART_IRQ_EN
  logic        irq;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic        txq[$];
  logic [7:0]  rxq[$];
  logic [31:0] rd;
  logic [31:0] held;

  assign uart_rxd = lb ? uart_txd : rxd_drv;

  avalon_uart #(.FIFO_DEPTH(8), .DEFAULT_DIV(434)) dut (
    .clk(clk), .rst(rst), .avn_read(avn_read), .avn_write(avn_write),
    .avn_address(avn_address), .avn_byte_enable(avn_byte_enable),
    .avn_writedata(avn_writedata), .avn_readdata(avn_readdata),
    .avn_waitrequest(avn_waitrequest), .uart_txd(uart_txd),
`ifdef AVALON_UART_IRQ_EN
    .irq(irq),
`endif
    .uart_rxd(uart_rxd)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d errors=%0d)", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    avn_write = 1'b1; avn_address = a; avn_writedata = d; avn_byte_enable = be;
    @(negedge clk);
    avn_write = 1'b0; avn_byte_enable = 4'h0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    avn_read = 1'b1; avn_address = a;
    @(negedge clk);
    avn_read = 1'b0;
    d = avn_readdata;
  endtask

  task automatic check_read(input string tag, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] d;
    exp_q.push_back(exp);
    bus_read(a, d);
    chk(tag, d, exp_q.pop_front());
  endtask

  // Expected serial waveform, one entry per clock, for a byte at the given divisor
  task automatic push_tx_bits(input logic [7:0] b, input int div);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++)
      for (int c = 0; c < div; c++) txq.push_back(frame[k]);
  endtask

  task automatic sample_tx(input string tag, input int n);
    logic e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      e = txq.pop_front();
      chk($sformatf("%s[%0d]", tag, i), {31'b0, uart_txd}, {31'b0, e});
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit, input int div);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      rxd_drv = frame[k];
      repeat (div) @(negedge clk);
    end
    rxd_drv = 1'b1;
    repeat (2 * div) @(negedge clk);
  endtask

  task automatic wait_rx_ready(input string tag);
    logic [31:0] d;
    int n;
    n = 0;
    d = '1;
    while (d[3] && n < 300) begin
      bus_read(A_STATUS, d);
      n++;
    end
    chk(tag, {31'b0, ~d[3]}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; avn_read = 1'b0; avn_write = 1'b0; avn_address = '0;
    avn_byte_enable = '0; avn_writedata = '0; lb = 1'b0; rxd_drv = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_readdata", avn_readdata, 32'h0);
    chk("rst_txd", {31'b0, uart_txd}, 32'd1);
    chk("rst_waitreq", {31'b0, avn_waitrequest}, 32'd0);
    check_read("rst_ctrl",   A_CTRL,   32'h0);
    check_read("rst_div",    A_DIV,    32'd434);
    check_read("rst_status", A_STATUS, 32'h0000_000A);
    check_read("rst_rxdata", A_RXDATA, 32'h8000_0000);
    check_read("rst_txdata", A_TXDATA, 32'h0);
    check_read("unmapped",   A_UNMAP,  32'h0);
`ifndef AVALON_UART_IRQ_EN
    bus_write(A_IE, 32'h7, 4'hF);
    check_read("ie_absent", A_IE, 32'h0);
`endif

    // Read data holds until the next read
    bus_read(A_DIV, held);
    repeat (5) @(negedge clk);
    chk("rd_hold", avn_readdata, 32'd434);

    // Divisor clamp and byte lanes, ctrl lane gating
    bus_write(A_DIV, 32'h0, 4'h3);
    check_read("div_clamp", A_DIV, 32'd2);
    bus_write(A_DIV, 32'h1234, 4'h2);
    check_read("div_lane", A_DIV, 32'h1202);
    bus_write(A_CTRL, 32'h3, 4'h0);
    check_read("ctrl_nolane", A_CTRL, 32'h0);

    // Single frame 0x55 at DIV=4
    bus_write(A_DIV, 32'd4, 4'hF);
    bus_write(A_CTRL, 32'h1, 4'hF);
    push_tx_bits(8'h55, 4);
    bus_write(A_TXDATA, 32'h55, 4'hF);
    sample_tx("tx55", 40);
    check_read("tx55_done", A_STATUS, 32'h0000_000A);

    // Fill TX FIFO with txen off; ninth byte is dropped
    bus_write(A_CTRL, 32'h0, 4'hF);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) push_tx_bits(8'(8'h10 + 8'(i * 37)), 4);
      bus_write(A_TXDATA, 32'(8'h10 + 8'(i * 37)), 4'h1);
    end
    check_read("txfill_status", A_STATUS, 32'h0000_0009);
    check_read("txfill_txdata", A_TXDATA, 32'h8000_0000);
    bus_write(A_CTRL, 32'h1, 4'hF);
    sample_tx("b2b", 320);
    chk("b2b_queue", 32'(txq.size()), 32'd0);
    check_read("b2b_done", A_STATUS, 32'h0000_000A);

    // Loopback 0xA3 at DIV=8
    bus_write(A_DIV, 32'd8, 4'hF);
    lb = 1'b1;
    bus_write(A_CTRL, 32'h3, 4'hF);
    rxq.push_back(8'hA3);
    bus_write(A_TXDATA, 32'hA3, 4'hF);
    wait_rx_ready("lb_wait");
    check_read("lb_data", A_RXDATA, {24'b0, rxq.pop_front()});
    check_read("lb_empty", A_RXDATA, 32'h8000_0000);
    repeat (20) @(negedge clk);
    lb = 1'b0;
    bus_write(A_CTRL, 32'h2, 4'hF);

    // Framing error: stop bit low
    send_rx(8'h5A, 1'b0, 8);
    check_read("ferr_status", A_STATUS, 32'h0000_004A);
    check_read("ferr_rxdata", A_RXDATA, 32'h8000_0000);
    bus_write(A_STATUS, 32'h40, 4'h1);
    check_read("ferr_clear", A_STATUS, 32'h0000_000A);

    // Overrun: nine frames without reading
    for (int i = 0; i < 9; i++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      if (i < 8) rxq.push_back(b);
      send_rx(b, 1'b1, 8);
    end
    check_read("ovr_status", A_STATUS, 32'h0000_0026);
    for (int i = 0; i < 8; i++)
      check_read($sformatf("ovr_data[%0d]", i), A_RXDATA, {24'b0, rxq.pop_front()});
    check_read("ovr_empty", A_RXDATA, 32'h8000_0000);
    bus_write(A_STATUS, 32'h20, 4'h1);
    check_read("ovr_clear", A_STATUS, 32'h0000_000A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
